// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory boot loader.
//   - loader_state_e : loader FSM states
//   - BYTES_PER_WORD : bytes assembled into one instruction word
//   - LEN_W          : width of the word-count header field
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        LEN0,   // waiting for header low byte
        LEN1,   // waiting for header high byte
        DATA,   // assembling a word from the byte stream
        WRITE,  // one-cycle write of the assembled word
        DONE,   // image loaded, core released
        ERR     // header word count larger than the memory
    } loader_state_e;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot loader between a serial byte source (typically a UART receiver) and
//   the instruction memory write port. It parses a frame of the form
//     LEN[7:0], LEN[15:8], LEN x 4 data bytes (each word little-endian)
//   writes the words to consecutive word addresses starting at 0, and holds
//   the core in reset until the whole image is in memory.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_valid    in   byte on rx_data is valid
//   rx_data     in   incoming byte
//   rx_ready    out  loader can accept a byte this cycle
//   reload      in   single-cycle pulse, restarts loading from DONE or ERR
//   imem_we     out  instruction memory write enable
//   imem_addr   out  word address of the write
//   imem_wdata  out  write data
//   core_rst_n  out  active-low core reset, low while loading
//   busy        out  load in progress
//   done        out  image loaded, core released
//   err         out  header word count exceeded the memory depth
//
// At SoC level the core reset is core_rst_n AND rst_n.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = imem_loader_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BC_W = $clog2(BYTES_PER_WORD);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES_PER_WORD - 1);

    // Depth and word counts are held one bit wider than the header so that a
    // memory of 2**LEN_W words still compares correctly against the header.
    localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_e     state_q,      state_d;
    logic [7:0]        len_lo_q,     len_lo_d;
    logic [BC_W-1:0]   byte_cnt_q,   byte_cnt_d;
    logic [LEN_W:0]    words_left_q, words_left_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic              core_rst_n_q, core_rst_n_d;

    logic              accept;
    logic [LEN_W:0]    len_full;

    // rx_ready is a pure state decode: it is low exactly in the states that
    // cannot absorb a byte, so no byte is ever dropped.
    assign rx_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
    assign accept   = rx_valid && rx_ready;
    assign len_full = (LEN_W + 1)'({rx_data, len_lo_q});

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the case statement can infer a latch.
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        byte_cnt_d   = byte_cnt_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rst_n_d = core_rst_n_q;

        unique case (state_q)
            LEN0: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = LEN1;
                end
            end

            LEN1: begin
                if (accept) begin
                    if (len_full == '0) begin
                        // Empty image: release the core straight away.
                        state_d      = DONE;
                        core_rst_n_d = 1'b1;
                    end else if (len_full > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        words_left_d = len_full;
                        addr_d       = '0;
                        byte_cnt_d   = '0;
                        state_d      = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    // Little-endian: the first byte ends up in bits [7:0]
                    // after four shifts.
                    wdata_d    = {rx_data, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                    if (byte_cnt_q == BC_LAST) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                // The write happens this cycle; advance for the next word.
                // For a full-depth image the address wraps to 0, which is
                // harmless because the loader stops in DONE.
                addr_d       = addr_q + ADDR_W'(1);
                words_left_d = words_left_q - (LEN_W + 1)'(1);
                if (words_left_q == (LEN_W + 1)'(1)) begin
                    state_d      = DONE;
                    core_rst_n_d = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end

            DONE, ERR: begin
                if (reload) begin
                    state_d      = LEN0;
                    core_rst_n_d = 1'b0;
                    addr_d       = '0;
                end
            end

            default: begin
                state_d      = LEN0;
                core_rst_n_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LEN0;
            len_lo_q     <= '0;
            byte_cnt_q   <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register see the
            // pre-edge value of every other register, as real flops do.
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            byte_cnt_q   <= byte_cnt_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    // Registered so it rises on the same edge that enters DONE.
    assign core_rst_n = core_rst_n_q;
    assign busy       = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    // ERR is only left by reload or reset, which makes err sticky.
    assign err        = (state_q == ERR);

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader (ADDR_W = 8, 256 words).
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              reload   = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model fed by the write port, sampled mid-cycle.
    logic [31:0]       tb_mem [DEPTH];
    int                we_cnt     = 0;
    int                ready_viol = 0;
    int                wide_pulse = 0;
    logic              we_prev    = 1'b0;
    logic [ADDR_W-1:0] last_addr  = '0;

    always @(negedge clk) begin
        if (imem_we) begin
            tb_mem[imem_addr] = imem_wdata;
            we_cnt++;
            last_addr = imem_addr;
            if (rx_ready) ready_viol++;
            if (we_prev) wide_pulse++;
        end
        we_prev = imem_we;
    end

    logic [31:0] basic_img [3] = '{32'h00500093, 32'h00A00113, 32'h00208133};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        n        = 0;
        do begin
            rdy = rx_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        rx_valid = 1'b0;
        if (!rdy) check("accept_timeout", {31'b0, rdy}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'hDEADBEEF;
    endtask

    function automatic logic [31:0] img_word(input int i);
        return (32'(i) * 32'h01030507) ^ 32'h5A000000;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rx_ready"},   {31'b0, rx_ready},   32'd1);
        check({pfx, "_imem_we"},    {31'b0, imem_we},    32'd0);
        check({pfx, "_imem_addr"},  32'(imem_addr),      32'd0);
        check({pfx, "_imem_wdata"}, imem_wdata,          32'd0);
        check({pfx, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd0);
        check({pfx, "_busy"},       {31'b0, busy},       32'd1);
        check({pfx, "_done"},       {31'b0, done},       32'd0);
        check({pfx, "_err"},        {31'b0, err},        32'd0);
    endtask

    // Called right after the final data byte was accepted.
    task automatic check_last_byte(input string pfx);
        check({pfx, "_we_after_last"},    {31'b0, imem_we},    32'd1);
        check({pfx, "_ready_in_write"},   {31'b0, rx_ready},   32'd0);
        check({pfx, "_done_not_yet"},     {31'b0, done},       32'd0);
        check({pfx, "_core_still_reset"}, {31'b0, core_rst_n}, 32'd0);
        tick();
        check({pfx, "_done"},       {31'b0, done},       32'd1);
        check({pfx, "_core_rst_n"}, {31'b0, core_rst_n}, 32'd1);
        check({pfx, "_busy"},       {31'b0, busy},       32'd0);
        check({pfx, "_we_dropped"}, {31'b0, imem_we},    32'd0);
    endtask

    task automatic check_basic_mem(input string pfx);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_mem%0d", pfx, i), tb_mem[i], basic_img[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        int bad;

        // ---------------- reset state ----------------
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        // ---------------- basic load, no gaps ----------------
        clear_mem();
        we0 = we_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_word(basic_img[i], 0);
        check_last_byte("basic");
        check_basic_mem("basic");
        check("basic_we_count", 32'(we_cnt - we0), 32'd3);
        check("basic_last_addr", 32'(last_addr), 32'd2);

        // ---------------- reload from DONE, backpressure ----------------
        pulse_reload();
        check("reload_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("reload_done",       {31'b0, done},       32'd0);
        check("reload_ready",      {31'b0, rx_ready},   32'd1);
        check("reload_addr",       32'(imem_addr),      32'd0);
        clear_mem();
        we0 = we_cnt;
        send_byte(8'h03, 3);
        send_byte(8'h00, 5);
        for (int i = 0; i < 3; i++) send_word(basic_img[i], 5);
        check_last_byte("bp");
        check_basic_mem("bp");
        check("bp_we_count",    32'(we_cnt - we0), 32'd3);
        check("bp_ready_in_we", 32'(ready_viol),   32'd0);
        check("bp_wide_pulse",  32'(wide_pulse),   32'd0);

        // ---------------- zero length ----------------
        pulse_reload();
        we0 = we_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("zero_done",       {31'b0, done},       32'd1);
        check("zero_core_rst_n", {31'b0, core_rst_n}, 32'd1);
        check("zero_busy",       {31'b0, busy},       32'd0);
        tick();
        check("zero_no_write",   32'(we_cnt - we0),   32'd0);

        // ---------------- oversize header (257 > 256) ----------------
        pulse_reload();
        we0 = we_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("over_err",        {31'b0, err},        32'd1);
        check("over_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        check("over_ready",      {31'b0, rx_ready},   32'd0);
        check("over_busy",       {31'b0, busy},       32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (5) tick();
        rx_valid = 1'b0;
        check("over_err_held",  {31'b0, err},      32'd1);
        check("over_ready_held",{31'b0, rx_ready}, 32'd0);
        check("over_no_write",  32'(we_cnt - we0), 32'd0);
        pulse_reload();
        check("over_reload_err",   {31'b0, err},      32'd0);
        check("over_reload_ready", {31'b0, rx_ready}, 32'd1);

        // ---------------- full-depth image (LEN = 256) ----------------
        clear_mem();
        we0 = we_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < DEPTH; i++) send_word(img_word(i), 0);
        check_last_byte("full");
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== img_word(i)) bad++;
        check("full_mem_mismatches", 32'(bad), 32'd0);
        check("full_word255",   tb_mem[255],      img_word(255));
        check("full_last_addr", 32'(last_addr),   32'd255);
        check("full_addr_wrap", 32'(imem_addr),   32'd0);
        check("full_we_count",  32'(we_cnt - we0), 32'd256);

        // ---------------- reload after done, 2-word image ----------------
        pulse_reload();
        check("re2_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        clear_mem();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        pulse_reload();  // must be ignored mid-load
        check("re2_ignore_busy", {31'b0, busy},     32'd1);
        check("re2_ignore_rdy",  {31'b0, rx_ready}, 32'd1);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        check_last_byte("re2");
        check("re2_mem0", tb_mem[0], 32'hCAFEF00D);
        check("re2_mem1", tb_mem[1], 32'h11223344);

        // ---------------- asynchronous reset mid-load ----------------
        pulse_reload();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(basic_img[0], 0);
        send_byte(basic_img[1][7:0], 0);
        send_byte(basic_img[1][15:8], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clear_mem();
        we0 = we_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_word(basic_img[i], 0);
        check_last_byte("after_rst");
        check_basic_mem("after_rst");
        check("after_rst_we_count", 32'(we_cnt - we0), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware counterpart to the simulation-only program load. Receives a byte stream, typically from a UART receiver, and assembles it into 32-bit little-endian words.
- Writes each word into the instruction memory write port.
- Holds the `riscv` core in reset (`core_rst_n` low) until the image is fully written, then releases it.
- Sits between the serial front end and the instruction memory/core reset tree at SoC top level.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; DEPTH = 2**ADDR_W words.
- LEN_W, 16, width of the word-count header field (fixed at 16 in this revision).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  byte on rx_data is valid.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at posedge.
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERR.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  write data.
- core_rst_n  output  1  active-low reset to the core; low while loading.
- busy  output  1  load in progress.
- done  output  1  image loaded, core released.
- err  output  1  header word count exceeded DEPTH.

Behaviour:
- Frame format: LEN[7:0], LEN[15:8], then LEN×4 data bytes. Each word is little-endian: the first byte goes to wdata[7:0].
- FSM states: LEN0, LEN1, DATA, WRITE, DONE, ERR. Reset state is LEN0.
- Reset values: rx_ready=1 (decoded from LEN0), imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=1, done=0, err=0. Internal byte_cnt=0, words_left=0.
- LEN0: on accept, store len_lo, go to LEN1.
- LEN1: on accept, form LEN = {rx_data, len_lo}, then:
  - LEN==0 → DONE.
  - LEN > DEPTH → ERR.
  - otherwise words_left=LEN, imem_addr=0, byte_cnt=0 → DATA.
- DATA: on accept, wdata <= {rx_data, wdata[31:8]} and byte_cnt++ (2-bit, wraps). The accept with byte_cnt==3 moves to WRITE.
- WRITE: imem_we=1 for exactly one cycle, rx_ready=0. On exit, imem_addr++ and words_left--:
  - words_left was 1 → DONE.
  - otherwise → DATA.
- DONE: rx_ready=0, done=1, busy=0. core_rst_n is a registered output, set to 1 on the WRITE→DONE or LEN1→DONE transition, so it goes high in the same cycle done first goes high.
- ERR: err=1 (sticky), rx_ready=0, core_rst_n stays 0, busy=0.
- reload pulse in DONE or ERR: the next cycle is LEN0 with core_rst_n=0, err=0, done=0, imem_addr=0. reload is ignored in all other states.
- Moore outputs: rx_ready=(state∈{LEN0,LEN1,DATA}); busy=(state∈{LEN0,LEN1,DATA,WRITE}).
- Latency: final data byte accepted at edge t; imem_we=1 during cycle t..t+1; done=1 and core_rst_n=1 from edge t+1.
- Backpressure and gaps: idle cycles (rx_valid=0) in any accepting state hold all state. The loader never drops a byte, because rx_ready is low exactly when no byte can be absorbed.
- Maximum load: LEN==DEPTH is legal. The final imem_addr increment wraps to 0, which is harmless because the FSM goes to DONE.
- Asynchronous reset mid-load: returns immediately to the reset values above; a partial image remains in memory and is overwritten by the next load.
- Arithmetic: words_left is LEN_W+1 bits wide. The comparison LEN > DEPTH is done at LEN_W+1 bits so that DEPTH=2**16 cannot overflow.

Decomposition:
- Package imem_loader_pkg:
  - state enum loader_state_e {LEN0, LEN1, DATA, WRITE, DONE, ERR}.
  - localparam BYTES_PER_WORD=4.
  - localparam LEN_W=16.
- No sub-module; byte assembly is a single shift register inside the block.
- Integration at top level: imem_* drives the instruction memory write port; core_rst_n AND rst_n drives the riscv reset.

Test Plan:
- Basic load: bytes 03 00, 93 00 50 00, 13 01 A0 00, 33 81 20 00 with no gaps → writes at addr 0/1/2 of 0x00500093, 0x00A00113, 0x00208133; done=1 and core_rst_n=1 one cycle after the last byte; core then runs and x2 becomes 15.
- Backpressure: same image with random 0–5 cycle rx_valid gaps → identical memory contents; imem_we pulses exactly 3 times, each 1 cycle; rx_ready low during each WRITE cycle.
- Zero length: 00 00 → done=1 and core_rst_n=1 the cycle after the second byte; imem_we never asserts.
- Oversize (ADDR_W=8): 01 01 (LEN=257) → err=1, core_rst_n=0, rx_ready=0 and all held. Then reload pulse and LEN=256 full image → done=1, last write at addr 255.
- Reset mid-load: deassert rst_n after 6 data bytes → all outputs at reset values asynchronously; a subsequent full load succeeds from addr 0.
- Reload after done: reload pulse → core_rst_n drops to 0 next cycle; second 2-word image written at addr 0/1, then core_rst_n returns to 1.
